// File: rtl/led_chain_shifter_pkg.sv
// Shared constants, FSM state encoding and width helper for the LED driver-chain shifter.
package led_chain_shifter_pkg;

    localparam int CH_PER_BOARD = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

    // Counter width that never collapses to zero bits for a terminal count of 1.
    function automatic int cnt_w(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/led_chain_shifter_sclk_gen.sv
// SCLK divider: c_clkdiv cycles low then c_clkdiv cycles high while enabled,
// with combinational strikes flagging the edge on which SCLK rises or falls.
module led_chain_shifter_sclk_gen #(
    parameter int c_clkdiv = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_mask_rise,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int c_cnt_w = $clog2(c_clkdiv + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_clkdiv - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sclk;
    logic               w_wrap;

    assign w_wrap = i_en && (r_cnt == c_cnt_last);
    // o_rise still fires when masked so the owner can time a full low phase.
    assign o_rise = w_wrap && !r_sclk;
    assign o_fall = w_wrap && r_sclk;
    assign o_sclk = r_sclk;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            if (r_sclk) begin
                r_sclk <= 1'b0;
            end else if (!i_mask_rise) begin
                r_sclk <= 1'b1;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_chain_shifter.sv
// Scans the framebuffer from the highest channel down and streams it MSB-first
// onto the daisy-chained LED driver bus, finishing each frame with a latch pulse.
module led_chain_shifter
    import led_chain_shifter_pkg::*;
#(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_channels  = c_ledboards * CH_PER_BOARD,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_clkdiv    = 2,
    parameter int c_latch_len = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic [c_addr_w-1:0] o_raddr,
    input  logic [c_bpc-1:0]    i_rdata,
    output logic                o_sclk,
    output logic                o_sdata,
    output logic                o_latch,
    output logic                o_busy,
    output logic                o_done
);

    localparam int c_bit_w   = cnt_w(c_bpc);
    localparam int c_latch_w = cnt_w(c_latch_len);

    localparam logic [c_addr_w-1:0]  c_addr_last  = c_addr_w'(c_channels - 1);
    localparam logic [c_addr_w-1:0]  c_addr_second = c_addr_w'(c_channels - 2);
    localparam logic [c_bit_w-1:0]   c_bit_last   = c_bit_w'(c_bpc - 1);
    localparam logic [c_latch_w-1:0] c_latch_last = c_latch_w'(c_latch_len - 1);

    state_t r_state;
    state_t w_state_next;

    logic [c_bpc-1:0]     r_shift;
    logic [c_bpc-1:0]     w_shift_next;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [c_addr_w-1:0]  r_word_cnt;
    logic [c_latch_w-1:0] r_latch_cnt;
    logic [c_addr_w-1:0]  r_raddr;
    logic                 r_latch;
    logic                 r_busy;
    logic                 r_done;

    logic w_sclk;
    logic w_rise;
    logic w_fall;
    logic w_sclk_en;
    logic w_gap;
    logic w_word_end;
    logic w_frame_end;

    led_chain_shifter_sclk_gen #(
        .c_clkdiv (c_clkdiv)
    ) u_sclk_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (w_sclk_en),
        .i_mask_rise (w_gap),
        .o_sclk      (w_sclk),
        .o_rise      (w_rise),
        .o_fall      (w_fall)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sclk_en    = (r_state == ST_SHIFT) || (r_state == ST_GAP);
        w_gap        = (r_state == ST_GAP);
        w_word_end   = (r_state == ST_SHIFT) && w_fall && (r_bit_cnt == '0);
        w_frame_end  = w_word_end && (r_word_cnt == '0);
        w_shift_next = r_shift << 1;
        unique case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_frame_end) w_state_next = ST_GAP;
            // Masked rise marks the end of the SCLK-low gap before the latch.
            ST_GAP:   if (w_rise) w_state_next = ST_LATCH;
            ST_LATCH: if (r_latch_cnt == '0) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_latch_cnt <= '0;
            r_raddr     <= c_addr_last;
            r_latch     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) r_busy <= 1'b1;
                end
                ST_LOAD: begin
                    r_shift    <= i_rdata;
                    r_raddr    <= c_addr_second;
                    r_bit_cnt  <= c_bit_last;
                    r_word_cnt <= c_addr_last;
                end
                ST_SHIFT: begin
                    if (w_fall) begin
                        if (r_bit_cnt != '0) begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end else if (r_word_cnt != '0) begin
                            // Next word has been waiting on i_rdata for a whole word time.
                            r_shift    <= i_rdata;
                            r_bit_cnt  <= c_bit_last;
                            r_word_cnt <= r_word_cnt - 1'b1;
                            if (r_raddr != '0) r_raddr <= r_raddr - 1'b1;
                        end else begin
                            r_shift <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_rise) begin
                        r_latch     <= 1'b1;
                        r_latch_cnt <= c_latch_last;
                    end
                end
                ST_LATCH: begin
                    if (r_latch_cnt == '0) begin
                        r_latch <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_raddr <= c_addr_last;
                    end else begin
                        r_latch_cnt <= r_latch_cnt - 1'b1;
                    end
                end
                default: begin
                    r_latch <= 1'b0;
                end
            endcase
        end
    end

    assign o_raddr = r_raddr;
    assign o_sclk  = w_sclk;
    assign o_sdata = r_shift[c_bpc-1];
    assign o_latch = r_latch;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_led_chain_shifter.sv
// Bench for led_chain_shifter: two one-board instances (SCLK divider 1 and 2),
// a registered-read framebuffer model and a bitstream scoreboard.
module tb_led_chain_shifter;

    localparam int NCH  = 32;
    localparam int NBIT = NCH * 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = 2'b00;
    logic [4:0]  raddr [2];
    logic [11:0] rdata [2];
    logic [1:0]  sclk, sdata, latch, busy, done;

    logic [11:0] mem [NCH];

    int n_checks = 0;
    int n_fail   = 0;

    bit exp_q [$];
    logic cap [NBIT];
    int sel = 1;
    bit mon_en = 1'b0;
    int rise_cnt, latch_pulses, latch_cycles, addr_err, setup_err;
    logic sclk_prev = 1'b0, sdata_prev = 1'b0, latch_prev = 1'b0;
    logic [4:0] raddr_prev = 5'd31;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        led_chain_shifter #(
            .c_ledboards (1),
            .c_bpc       (12),
            .c_clkdiv    (gi + 1),
            .c_latch_len (2)
        ) u_dut (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_start (start[gi]),
            .o_raddr (raddr[gi]),
            .i_rdata (rdata[gi]),
            .o_sclk  (sclk[gi]),
            .o_sdata (sdata[gi]),
            .o_latch (latch[gi]),
            .o_busy  (busy[gi]),
            .o_done  (done[gi])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) rdata[i] <= mem[raddr[i]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: one expected bit popped per SCLK rise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sclk[sel] && !sclk_prev) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_bit", 32'(rise_cnt), 32'(NBIT - 1));
                end else begin
                    check_eq("bit", 32'(sdata[sel]), 32'(exp_q.pop_front()));
                end
                if (rise_cnt < NBIT) cap[rise_cnt] = sdata[sel];
                if (sdata[sel] !== sdata_prev) setup_err++;
                rise_cnt++;
            end
            if (latch[sel] && !latch_prev) latch_pulses++;
            if (latch[sel]) latch_cycles++;
            if (raddr[sel] != raddr_prev) begin
                if (!((raddr[sel] == raddr_prev - 5'd1) || (raddr[sel] == 5'd31 && done[sel])))
                    addr_err++;
            end
        end
        sclk_prev  = sclk[sel];
        sdata_prev = sdata[sel];
        latch_prev = latch[sel];
        raddr_prev = raddr[sel];
    end

    task automatic run_frame(input int s, input int exp_len, input bit mid_start,
                             input bit pre_started, input bit chain);
        int t;
        bit seen;
        sel = s;
        exp_q.delete();
        for (int w = NCH - 1; w >= 0; w--)
            for (int b = 11; b >= 0; b--) exp_q.push_back(mem[w][b]);
        rise_cnt = 0; latch_pulses = 0; latch_cycles = 0; addr_err = 0; setup_err = 0;
        mon_en = 1'b1;
        if (!pre_started) begin
            @(posedge clk); #1;
            start[s] = 1'b1;
        end
        @(posedge clk); #1;
        start[s] = 1'b0;
        check_eq("busy_after_start", 32'(busy[s]), 32'd1);
        @(posedge clk);
        t = 0;
        seen = 1'b0;
        while (!seen && t < exp_len + 50) begin
            @(posedge clk);
            t++;
            #1;
            start[s] = (mid_start && t == exp_len / 2);
            if (done[s]) seen = 1'b1;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("frame_len", 32'(t), 32'(exp_len));
        check_eq("sclk_rises", 32'(rise_cnt), 32'(NBIT));
        check_eq("queue_left", 32'(exp_q.size()), 32'd0);
        check_eq("latch_pulses", 32'(latch_pulses), 32'd1);
        check_eq("latch_cycles", 32'(latch_cycles), 32'd2);
        check_eq("addr_seq_err", 32'(addr_err), 32'd0);
        check_eq("setup_err", 32'(setup_err), 32'd0);
        check_eq("busy_at_done", 32'(busy[s]), 32'd0);
        check_eq("raddr_at_done", 32'(raddr[s]), 32'd31);
        $display("frame dut=%0d clkdiv=%0d len=%0d rises=%0d latches=%0d", s, s + 1, t, rise_cnt, latch_pulses);
        if (chain) begin
            start[s] = 1'b1;
        end else begin
            @(posedge clk); #1;
            check_eq("done_one_cycle", 32'(done[s]), 32'd0);
        end
    endtask

    initial begin
        int s;
        bit saw_activity;
        for (int i = 0; i < NCH; i++) mem[i] = 12'((i * 32'h101) & 32'hFFF);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_raddr", 32'(raddr[d]), 32'd31);
            check_eq("rst_outs", {27'd0, sclk[d], sdata[d], latch[d], busy[d], done[d]}, 32'd0);
        end
        rst = 1'b0;

        // Divider 2, start pulsed mid-frame, then a back-to-back frame from the done cycle.
        run_frame(1, NBIT * 4 + 2 + 2, 1'b1, 1'b0, 1'b1);
        mem[31] = 12'hFFF;
        mem[30] = 12'h000;
        run_frame(1, NBIT * 4 + 2 + 2, 1'b0, 1'b1, 1'b0);
        check_eq("bnd_bit0", 32'(cap[0]), 32'd1);
        check_eq("bnd_bit11", 32'(cap[11]), 32'd1);
        check_eq("bnd_bit12", 32'(cap[12]), 32'd0);
        check_eq("bnd_bit23", 32'(cap[23]), 32'd0);

        for (int i = 0; i < NCH; i++) mem[i] = 12'((i * 32'h101) & 32'hFFF);
        run_frame(0, NBIT * 2 + 1 + 2, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a divider-2 frame.
        mon_en = 1'b0;
        s = 1;
        sel = s;
        @(posedge clk); #1;
        start[s] = 1'b1;
        @(posedge clk); #1;
        start[s] = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(busy[s]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_raddr", 32'(raddr[s]), 32'd31);
        check_eq("midrst_outs", {27'd0, sclk[s], sdata[s], latch[s], busy[s], done[s]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        saw_activity = 1'b0;
        repeat (1700) begin
            @(posedge clk); #1;
            if (latch[s] || busy[s] || done[s]) saw_activity = 1'b1;
        end
        check_eq("midrst_no_latch", 32'(saw_activity), 32'd0);
        $display("reset-abort dut=%0d idle_after=%0d", s, !saw_activity);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
